// File: rtl/dpram_be_sclk.sv
// Single-clock simple dual-port RAM with byte-enable writes and byte-granular read bypass.
// Also has an optional output register and an optional post-reset clear sequencer.
module dpram_be_sclk #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int ENABLE_BYPASS  = 1,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     raddr,
    input  logic                      re,
    output logic [DATA_WIDTH-1:0]     dout,
    input  logic [ADDR_WIDTH-1:0]     waddr,
    input  logic                      we,
    input  logic [DATA_WIDTH/8-1:0]   be,
    input  logic [DATA_WIDTH-1:0]     din,
    output logic                      init_busy
);

    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {CLEAR, READY} state_t;

    generate
        if ((DATA_WIDTH % 8) != 0) begin : g_width_check
            $error("dpram_be_sclk: DATA_WIDTH must be a multiple of 8");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  re_eff;
    logic                  we_eff;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    assign re_eff = re & ~init_busy;
    assign we_eff = we & ~init_busy;

    generate
        if (CLEAR_ON_RESET != 0) begin : g_clear
            state_t                state;
            state_t                state_nx;
            logic [ADDR_WIDTH-1:0] count;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state <= CLEAR;
                    count <= '0;
                end else begin
                    state <= state_nx;
                    if (state == CLEAR)
                        count <= count + 1'b1;
                end
            end

            // count wraps to 0 on the same edge that hands the memory over
            always_comb begin
                state_nx = state;
                if (state == CLEAR && count == '1)
                    state_nx = READY;
            end

            always_comb begin
                init_busy = (state == CLEAR);
                clr_we    = (state == CLEAR) && !rst;
                clr_addr  = count;
            end
        end else begin : g_no_clear
            assign init_busy = 1'b0;
            assign clr_we    = 1'b0;
            assign clr_addr  = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (we_eff) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (be[i])
                    mem[waddr][8*i +: 8] <= din[8*i +: 8];
            end
        end
    end

    // Same-address read sees enabled bytes of the incoming write, rest from the array
    always_comb begin
        rd_word = mem[raddr];
        if (ENABLE_BYPASS != 0 && we_eff && waddr == raddr) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (be[i])
                    rd_word[8*i +: 8] = din[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            rdata <= '0;
        else if (re_eff)
            rdata <= rd_word;
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  re_d;
            logic [DATA_WIDTH-1:0] stage;

            always_ff @(posedge clk) begin
                if (rst) begin
                    re_d  <= 1'b0;
                    stage <= '0;
                end else begin
                    re_d <= re_eff;
                    if (re_d)
                        stage <= rdata;
                end
            end

            assign dout = stage;
        end else begin : g_no_out_reg
            assign dout = rdata;
        end
    endgenerate

endmodule
